// File: rtl/gpio_int_ack_host.sv
// CPU-side responder for the INTR/INTA_N/INT_CODE handshake, with a captured-code FIFO and register bus.
// Optional macro GPIO_INT_HOST_TIMEOUT_EN adds the acknowledge timeout, TOUT state and STATUS.ERR.
module gpio_int_ack_host #(
  parameter int CODE_W     = 3,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ACK_LEN    = 4,
  parameter int TO_CYC     = 16
) (
  input  logic              clk_50m,
  input  logic              rst_50m,
  input  logic              INTR,
  input  logic [CODE_W-1:0] INT_CODE,
  output logic              INTA_N,
  input  logic              i_csn_50m,
  input  logic              i_wr_50m,
  input  logic              i_rd_50m,
  input  logic [ADDR_W-1:0] i_addr_50m,
  input  logic [DATA_W-1:0] i_datin_50m,
  output logic [DATA_W-1:0] o_datout_50m,
  output logic              wr_valid,
  output logic              rd_valid
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int PIPE_N    = 6;
  localparam int ACK_MAX_N = (ACK_LEN > TO_CYC) ? ACK_LEN : TO_CYC;
  localparam int ACK_CNT_W = $clog2(ACK_MAX_N) + 1;

  localparam logic [ADDR_W-1:0]    ADDR_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0]    ADDR_STATUS = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]    ADDR_CODE   = ADDR_W'(2);
  localparam logic [CNT_W-1:0]     CNT_FULL    = CNT_W'(FIFO_DEPTH);
  localparam logic [ACK_CNT_W-1:0] ACK_LAST    = ACK_CNT_W'(ACK_LEN - 1);
  localparam logic [ACK_CNT_W-1:0] ACK_SAT     = ACK_CNT_W'(ACK_MAX_N - 1);
`ifdef GPIO_INT_HOST_TIMEOUT_EN
  localparam logic [ACK_CNT_W-1:0] TO_LAST     = ACK_CNT_W'(TO_CYC - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_TOUT    = 2'd3
  } state_t;

  logic                 csn_q_r;
  logic                 csn_fall_s;
  logic                 rd_fire_s;
  logic                 ctrl_wr_s;
  logic                 en_r;
  logic                 err_s;
  logic                 unused_s;

  logic [CODE_W-1:0]    mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 empty_s;
  logic                 full_s;
  logic                 push_s;
  logic                 push_ok_s;
  logic                 pop_s;

  logic [DATA_W-1:0]    rd_data_s;
  logic [PIPE_N-1:0]    pipe_vld_r;
  logic [DATA_W-1:0]    pipe_dat_r [PIPE_N];

  state_t               state_r, state_s;
  logic [ACK_CNT_W-1:0] ack_cnt_r, ack_cnt_s;
  logic                 rel_cnt_r, rel_cnt_s;
  logic                 pushed_r, pushed_s;
  logic                 inta_n_s;

  assign unused_s = ^{1'b0, i_datin_50m[DATA_W-1:1]};

  // Chip-select edge detector for the bus strobes
  always_ff @(posedge clk_50m or posedge rst_50m) begin
    if (rst_50m) begin
      csn_q_r <= 1'b1;
    end else begin
      csn_q_r <= i_csn_50m;
    end
  end

  assign csn_fall_s = csn_q_r & ~i_csn_50m;
  assign wr_valid   = csn_fall_s & i_wr_50m;
  assign rd_fire_s  = csn_fall_s & i_rd_50m;
  assign ctrl_wr_s  = wr_valid & (i_addr_50m == ADDR_CTRL);

  // CTRL.EN register; ERR_CLR is a write-time pulse and never stored
  always_ff @(posedge clk_50m or posedge rst_50m) begin
    if (rst_50m) begin
      en_r <= 1'b0;
    end else if (ctrl_wr_s) begin
      en_r <= i_datin_50m[0];
    end else begin
      en_r <= en_r;
    end
  end

`ifdef GPIO_INT_HOST_TIMEOUT_EN
  logic err_r;
  logic err_clr_s;
  logic tout_set_s;

  assign err_clr_s = ctrl_wr_s & i_datin_50m[1];

  // Sticky timeout error; a timeout in the same cycle as ERR_CLR wins
  always_ff @(posedge clk_50m or posedge rst_50m) begin
    if (rst_50m) begin
      err_r <= 1'b0;
    end else if (tout_set_s) begin
      err_r <= 1'b1;
    end else if (err_clr_s) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_s = err_r;
`else
  assign err_s = 1'b0;
`endif

  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign full_s    = (count_r == CNT_FULL);
  assign pop_s     = rd_fire_s & (i_addr_50m == ADDR_CODE) & ~empty_s;
  assign push_ok_s = push_s & (~full_s | pop_s);

  // Code FIFO storage
  always_ff @(posedge clk_50m) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= INT_CODE;
    end
  end

  // Code FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely
  always_ff @(posedge clk_50m or posedge rst_50m) begin
    if (rst_50m) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Register read mux, sampled on the chip-select falling edge
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    case (i_addr_50m)
      ADDR_CTRL: begin
        rd_data_s[0] = en_r;
      end
      ADDR_STATUS: begin
        rd_data_s[0]   = ~empty_s;
        rd_data_s[1]   = full_s;
        rd_data_s[2]   = err_s;
        rd_data_s[7:4] = 4'(count_r);
      end
      ADDR_CODE: begin
        if (!empty_s) begin
          rd_data_s[CODE_W-1:0] = mem_r[rd_ptr_r];
        end else begin
          rd_data_s = {DATA_W{1'b0}};
        end
      end
      default: begin
        rd_data_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Read latency pipe; each read carries its own token so reads can overlap
  always_ff @(posedge clk_50m or posedge rst_50m) begin
    if (rst_50m) begin
      pipe_vld_r <= {PIPE_N{1'b0}};
      for (int i = 0; i < PIPE_N; i++) begin
        pipe_dat_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      pipe_vld_r    <= {pipe_vld_r[PIPE_N-2:0], rd_fire_s};
      pipe_dat_r[0] <= rd_data_s;
      for (int i = 1; i < PIPE_N; i++) begin
        pipe_dat_r[i] <= pipe_dat_r[i-1];
      end
    end
  end

  // Read output stage; data holds the last returned value
  always_ff @(posedge clk_50m or posedge rst_50m) begin
    if (rst_50m) begin
      rd_valid     <= 1'b0;
      o_datout_50m <= {DATA_W{1'b0}};
    end else begin
      rd_valid <= pipe_vld_r[PIPE_N-1];
      if (pipe_vld_r[PIPE_N-1]) begin
        o_datout_50m <= pipe_dat_r[PIPE_N-1];
      end else begin
        o_datout_50m <= o_datout_50m;
      end
    end
  end

  // Handshake FSM state; INTA_N is registered so reset releases it immediately
  always_ff @(posedge clk_50m or posedge rst_50m) begin
    if (rst_50m) begin
      state_r   <= ST_IDLE;
      ack_cnt_r <= {ACK_CNT_W{1'b0}};
      rel_cnt_r <= 1'b0;
      pushed_r  <= 1'b0;
      INTA_N    <= 1'b1;
    end else begin
      state_r   <= state_s;
      ack_cnt_r <= ack_cnt_s;
      rel_cnt_r <= rel_cnt_s;
      pushed_r  <= pushed_s;
      INTA_N    <= inta_n_s;
    end
  end

  // Handshake FSM next state; ack_cnt_r counts cycles since INTA_N fell
  always_comb begin
    state_s   = state_r;
    ack_cnt_s = ack_cnt_r;
    rel_cnt_s = rel_cnt_r;
    pushed_s  = pushed_r;
    inta_n_s  = 1'b1;
    push_s    = 1'b0;
`ifdef GPIO_INT_HOST_TIMEOUT_EN
    tout_set_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (en_r && INTR && !full_s) begin
          state_s   = ST_ACK;
          ack_cnt_s = {ACK_CNT_W{1'b0}};
          pushed_s  = 1'b0;
          inta_n_s  = 1'b0;
        end else begin
          inta_n_s  = 1'b1;
        end
      end
      ST_ACK: begin
        push_s = ~INTR & ~pushed_r;
        if (push_s) begin
          pushed_s = 1'b1;
        end else begin
          pushed_s = pushed_r;
        end
        if (ack_cnt_r != ACK_SAT) begin
          ack_cnt_s = ack_cnt_r + ACK_CNT_W'(1);
        end else begin
          ack_cnt_s = ack_cnt_r;
        end
        if ((ack_cnt_r >= ACK_LAST) && (pushed_r || !INTR)) begin
          state_s   = ST_RELEASE;
          rel_cnt_s = 1'b0;
          inta_n_s  = 1'b1;
`ifdef GPIO_INT_HOST_TIMEOUT_EN
        end else if (!pushed_r && INTR && (ack_cnt_r == TO_LAST)) begin
          state_s    = ST_TOUT;
          tout_set_s = 1'b1;
          inta_n_s   = 1'b1;
`endif
        end else begin
          inta_n_s  = 1'b0;
        end
      end
      ST_RELEASE: begin
        inta_n_s = 1'b1;
        if (rel_cnt_r) begin
          state_s   = ST_IDLE;
        end else begin
          rel_cnt_s = 1'b1;
        end
      end
      ST_TOUT: begin
        state_s   = ST_RELEASE;
        rel_cnt_s = 1'b0;
        inta_n_s  = 1'b1;
      end
      default: begin
        state_s  = ST_IDLE;
        inta_n_s = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_gpio_int_ack_host.sv
// Directed bench for gpio_int_ack_host: reads are checked by a scoreboard of expected data and F+7 timing.
module tb_gpio_int_ack_host;

  logic       clk_50m = 1'b0;
  logic       rst_50m = 1'b1;
  logic       INTR = 1'b0;
  logic [2:0] INT_CODE = 3'd0;
  logic       INTA_N;
  logic       i_csn_50m = 1'b1;
  logic       i_wr_50m = 1'b0;
  logic       i_rd_50m = 1'b0;
  logic [3:0] i_addr_50m = 4'd0;
  logic [7:0] i_datin_50m = 8'd0;
  logic [7:0] o_datout_50m;
  logic       wr_valid;
  logic       rd_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] exp_q[$];
  int         cyc_q[$];

  gpio_int_ack_host dut (
    .clk_50m      (clk_50m),
    .rst_50m      (rst_50m),
    .INTR         (INTR),
    .INT_CODE     (INT_CODE),
    .INTA_N       (INTA_N),
    .i_csn_50m    (i_csn_50m),
    .i_wr_50m     (i_wr_50m),
    .i_rd_50m     (i_rd_50m),
    .i_addr_50m   (i_addr_50m),
    .i_datin_50m  (i_datin_50m),
    .o_datout_50m (o_datout_50m),
    .wr_valid     (wr_valid),
    .rd_valid     (rd_valid)
  );

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rd_valid pops one expected read and checks data and latency
  always @(negedge clk_50m) begin
    if (!rst_50m && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        int f;
        e = exp_q.pop_front();
        f = cyc_q.pop_front();
        chk("rd_data", {24'd0, o_datout_50m}, {24'd0, e});
        chk("rd_latency", cyc - f, 32'd7);
      end
    end
  end

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk_50m);
    i_csn_50m = 1'b0; i_wr_50m = 1'b1; i_addr_50m = a; i_datin_50m = d;
    #1 chk("wr_valid_fall", {31'd0, wr_valid}, 32'd1);
    @(negedge clk_50m);
    i_csn_50m = 1'b1; i_wr_50m = 1'b0;
    #1 chk("wr_valid_after", {31'd0, wr_valid}, 32'd0);
  endtask

  task automatic bus_rd(input logic [3:0] a, input logic [7:0] e);
    @(negedge clk_50m);
    i_csn_50m = 1'b0; i_rd_50m = 1'b1; i_addr_50m = a;
    exp_q.push_back(e);
    cyc_q.push_back(cyc);
    @(negedge clk_50m);
    i_csn_50m = 1'b1; i_rd_50m = 1'b0;
  endtask

  task automatic wait_reads();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk_50m);
      n++;
    end
    chk("rd_drain", exp_q.size(), 32'd0);
  endtask

  // Controller side of one handshake: wait for INTA_N, drop INTR the next cycle, measure the low pulse
  task automatic handshake(input string tag, input bit pop_now, input logic [7:0] pop_exp);
    int n = 0;
    int low_n = 1;
    while (INTA_N !== 1'b0 && n < 40) begin
      @(negedge clk_50m);
      n++;
    end
    chk({tag, "_ack_seen"}, {31'd0, INTA_N}, 32'd0);
    @(negedge clk_50m);
    INTR = 1'b0;
    if (pop_now) begin
      i_csn_50m = 1'b0; i_rd_50m = 1'b1; i_addr_50m = 4'd2;
      exp_q.push_back(pop_exp);
      cyc_q.push_back(cyc);
    end
    while (INTA_N === 1'b0 && low_n < 40) begin
      low_n++;
      @(negedge clk_50m);
      i_csn_50m = 1'b1; i_rd_50m = 1'b0;
    end
    chk({tag, "_low_len"}, low_n, 32'd4);
  endtask

  task automatic irq(input logic [2:0] code, input string tag);
    @(negedge clk_50m);
    INTR = 1'b1; INT_CODE = code;
    handshake(tag, 1'b0, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int low_n;
    bit seen_low;

    // Reset held with INTR pending
    INTR = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_50m);
      chk("rst_inta_n", {31'd0, INTA_N}, 32'd1);
      chk("rst_datout", {24'd0, o_datout_50m}, 32'd0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    end
    INTR = 1'b0;
    rst_50m = 1'b0;

    // Bus timing and CTRL readback
    bus_wr(4'd0, 8'h01);
    bus_rd(4'd0, 8'h01);
    bus_rd(4'd5, 8'h00);
    wait_reads();

    // Single interrupt
    irq(3'd5, "single");
    bus_rd(4'd1, 8'h11);
    bus_rd(4'd2, 8'h05);
    bus_rd(4'd1, 8'h00);
    bus_rd(4'd2, 8'h00);
    wait_reads();

    // Full backpressure
    for (int k = 1; k <= 4; k++) irq(3'(k), "fill");
    @(negedge clk_50m);
    INTR = 1'b1; INT_CODE = 3'd5;
    seen_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_50m);
      if (INTA_N !== 1'b1) seen_low = 1'b1;
    end
    chk("full_withheld", {31'd0, seen_low}, 32'd0);
    bus_rd(4'd1, 8'h43);
    wait_reads();
    chk("full_still_high", {31'd0, INTA_N}, 32'd1);
    bus_rd(4'd2, 8'h01);
    handshake("fifth", 1'b0, 8'd0);
    bus_rd(4'd1, 8'h43);
    bus_rd(4'd2, 8'h02);
    bus_rd(4'd2, 8'h03);
    bus_rd(4'd2, 8'h04);
    bus_rd(4'd2, 8'h05);
    bus_rd(4'd1, 8'h00);
    wait_reads();

    // Pop at count 1 in the same cycle as a push
    irq(3'd6, "pre_pop");
    @(negedge clk_50m);
    INTR = 1'b1; INT_CODE = 3'd7;
    handshake("pushpop", 1'b1, 8'h06);
    bus_rd(4'd1, 8'h11);
    bus_rd(4'd2, 8'h07);
    bus_rd(4'd1, 8'h00);
    wait_reads();

    // INTR held high through the acknowledge
    @(negedge clk_50m);
    INTR = 1'b1; INT_CODE = 3'd2;
    low_n = 0;
    while (INTA_N !== 1'b0 && low_n < 40) begin
      @(negedge clk_50m);
      low_n++;
    end
    chk("hold_ack_seen", {31'd0, INTA_N}, 32'd0);
    low_n = 0;
`ifdef GPIO_INT_HOST_TIMEOUT_EN
    while (INTA_N === 1'b0 && low_n < 64) begin
      low_n++;
      @(negedge clk_50m);
    end
    INTR = 1'b0;
    chk("tout_low_len", low_n, 32'd16);
    bus_rd(4'd1, 8'h04);
    wait_reads();
    bus_wr(4'd0, 8'h03);
    bus_rd(4'd1, 8'h00);
    bus_rd(4'd0, 8'h01);
    wait_reads();
`else
    while (INTA_N === 1'b0 && low_n < 24) begin
      low_n++;
      @(negedge clk_50m);
    end
    chk("hold_low_len", low_n, 32'd24);
    INTR = 1'b0;
    @(negedge clk_50m);
    chk("hold_release", {31'd0, INTA_N}, 32'd1);
    bus_wr(4'd0, 8'h03);
    bus_rd(4'd1, 8'h11);
    bus_rd(4'd2, 8'h02);
    bus_rd(4'd0, 8'h01);
    wait_reads();
`endif

    // Reset two cycles into an acknowledge
    @(negedge clk_50m);
    INTR = 1'b1; INT_CODE = 3'd4;
    low_n = 0;
    while (INTA_N !== 1'b0 && low_n < 40) begin
      @(negedge clk_50m);
      low_n++;
    end
    chk("rst_ack_seen", {31'd0, INTA_N}, 32'd0);
    @(negedge clk_50m);
    #3 rst_50m = 1'b1;
    #1 chk("rst_async_inta_n", {31'd0, INTA_N}, 32'd1);
    @(negedge clk_50m);
    @(negedge clk_50m);
    INTR = 1'b0;
    rst_50m = 1'b0;
    chk("rst_mid_inta_n", {31'd0, INTA_N}, 32'd1);
    bus_rd(4'd1, 8'h00);
    bus_rd(4'd0, 8'h00);
    wait_reads();
    bus_wr(4'd0, 8'h01);
    irq(3'd3, "after_rst");
    bus_rd(4'd2, 8'h03);
    wait_reads();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_int_ack_host.md
Name: gpio_int_ack_host

Overview:
- CPU-side responder for the GPIO interrupt controller's INTR/INTA_N/INT_CODE handshake.
- Detects INTR, drives the INTA_N acknowledge pulse and captures INT_CODE into a small FIFO.
- Exposes control, status and captured codes to the data bus through the 50 MHz register interface (CSN/WR/RD, fixed read latency).
- Sits between gpio_int_top and the bus master, in place of a hand-written CPU interrupt routine.

Parameters:
CODE_W, 3, width of INT_CODE
DATA_W, 8, bus data width (must be >= CODE_W and >= 8)
ADDR_W, 4, bus address width
FIFO_DEPTH, 4, captured-code FIFO entries (power of two, >= 2)
ACK_LEN, 4, cycles INTA_N is held low per acknowledge (>= 2)
TO_CYC, 16, cycles to wait for INTR to drop after INTA_N falls

Ports:
clk_50m  in  1  system clock, all logic on posedge
rst_50m  in  1  asynchronous active-high reset
INTR  in  1  interrupt request from controller
INT_CODE  in  CODE_W  interrupt source code from controller
INTA_N  out  1  interrupt acknowledge, active low
i_csn_50m  in  1  bus chip select, active low
i_wr_50m  in  1  bus write strobe
i_rd_50m  in  1  bus read strobe
i_addr_50m  in  ADDR_W  register address
i_datin_50m  in  DATA_W  write data
o_datout_50m  out  DATA_W  read data
wr_valid  out  1  write accepted
rd_valid  out  1  read data valid

Behaviour:
Reset values:
- INTA_N=1; o_datout_50m=0; rd_valid=0; wr_valid=0.
- FIFO empty; CTRL=0; ERR=0; FSM in IDLE; read pipe cleared.
- Asserting reset mid-handshake releases INTA_N high asynchronously.

Bus write:
- csn_q = i_csn_50m registered.
- wr_valid = csn_q & ~i_csn_50m & i_wr_50m, combinational, same cycle as the CSN falling edge.
- Register update occurs on that edge.

Bus read:
- Fall cycle F: CSN falling with i_rd_50m. The addressed register is sampled at F and a token enters a 7-stage pipe.
- At F+7: rd_valid=1 for one cycle and o_datout_50m gets the sampled data.
- o_datout_50m holds the last read value otherwise. Overlapping reads are pipelined independently.

Register map:
- 0 CTRL (RW): bit0 EN; bit1 ERR_CLR, write-1 self-clearing.
- 1 STATUS (RO): bit0 NOT_EMPTY; bit1 FULL; bit2 ERR; bits[7:4] count.
- 2 CODE (RO): FIFO head zero-extended; the read pops at F; reading when empty returns 0 with no pop.
- Other addresses read 0; writes to them are ignored.

FSM:
- IDLE: if EN & INTR & !FULL, go to ACK.
- ACK: INTA_N=0 for ACK_LEN cycles, starting the cycle after entry. The controller drops INTR the cycle after INTA_N falls.
  - On the first cycle INTA_N is low and INTR==0, INT_CODE is pushed (cycle fall+1).
  - If INTR is still high TO_CYC cycles after the INTA_N fall, go to TOUT.
- RELEASE: INTA_N=1; wait 2 cycles, then go to IDLE.
  - If INTR is high again, a new acknowledge is allowed only after those 2 cycles.
- TOUT: set ERR, INTA_N=1, no push, go to RELEASE.

FIFO boundary conditions:
- FULL: acknowledge is withheld and INTR stays pending; no data is lost.
- Push and pop in the same cycle: count unchanged; pointers wrap modulo FIFO_DEPTH.
- Pop when count=1 with a simultaneous push: the new entry becomes the head.

Other rules:
- EN cleared mid-ACK: the handshake completes; no new acknowledge starts.
- ERR_CLR and a TOUT entry in the same cycle: ERR stays set.

Optional Feature:
Macro: GPIO_INT_HOST_TIMEOUT_EN.
- Defined: TO_CYC timeout, TOUT state and STATUS.ERR are implemented as above.
- Undefined: ACK holds INTA_N low until INTR drops (minimum ACK_LEN cycles); no TOUT state; STATUS.ERR reads 0; ERR_CLR has no effect.

Test Plan:
- Reset: rst_50m=1 for 5 cycles with INTR=1 -> INTA_N=1, o_datout_50m=0, rd_valid=0 throughout.
- Bus timing: write CTRL=0x01 -> wr_valid=1 on the CSN-fall cycle. Read addr 0 -> rd_valid at F+7, o_datout_50m=0x01.
- Single interrupt: EN=1, INTR=1, INT_CODE=3'd5, controller drops INTR one cycle after INTA_N falls -> INTA_N low for 4 cycles. STATUS then reads 0x11. Read CODE -> 0x05, STATUS becomes 0x00.
- Full backpressure: 5 interrupts with codes 1..5 and no pops -> 4 acknowledges; STATUS=0x43; INTA_N stays 1 while INTR is held. Pop one -> 5th acknowledge occurs; CODE reads 1,2,3,4,5 in order.
- Timeout (macro defined): INTR held high through INTA_N low -> after 16 cycles INTA_N=1, STATUS.bit2=1, no push. Write CTRL=0x03 -> ERR=0.
- Reset mid-ACK: assert rst_50m 2 cycles into ACK -> INTA_N=1 immediately, FIFO empty, FSM in IDLE after release.
